// File: rtl/keystream_pkg.sv
// Shared constants and FSM state encoding for the DRBG keystream buffer.
package keystream_pkg;

   localparam int unsigned DRBG_WORD_W = 256;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      WAIT     = 3'd2,
      RSD_REQ  = 3'd3,
      RSD_WAIT = 3'd4
   } ks_state_t;

   // Number of keystream slices per DRBG word for a given slice width.
   function automatic int unsigned slices(input int unsigned out_width);
      return DRBG_WORD_W / out_width;
   endfunction

endpackage

// File: rtl/keystream_word_fifo.sv
// Two-entry FIFO of 256-bit DRBG words; exposes the head and the entry behind it.
module keystream_word_fifo
   import keystream_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DRBG_WORD_W-1:0] wr_data,
   output logic [DRBG_WORD_W-1:0] head,
   output logic [DRBG_WORD_W-1:0] next_word,
   output logic [1:0]             count
);

   logic [DRBG_WORD_W-1:0] mem [2];
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic                   do_push;
   logic                   do_pop;

   assign do_pop  = pop && (count != 2'd0);
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head      = mem[rd_ptr];
   assign next_word = mem[~rd_ptr];

endmodule

// File: rtl/drbg_keystream_buffer.sv
// Requests/reseeds the Hash_DRBG, buffers two words, and streams them out as OUT_WIDTH slices.
// Optional macro KEYSTREAM_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module drbg_keystream_buffer
   import keystream_pkg::*;
#(
   parameter int unsigned OUT_WIDTH    = 32,
   parameter int unsigned RESEED_WORDS = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   output logic                   drbg_next,
   output logic                   drbg_reseed,
   input  logic [DRBG_WORD_W-1:0] drbg_random_bits,
   input  logic                   drbg_next_ready,
   input  logic                   drbg_busy,
   output logic [OUT_WIDTH-1:0]   ks_data,
   output logic                   ks_valid,
   input  logic                   ks_ready,
   output logic [31:0]            words_generated,
   output logic                   underrun
`ifdef KEYSTREAM_UNDERRUN_CNT_EN
  ,output logic [15:0]            underrun_count
`endif
);

   localparam int unsigned       SLICES     = slices(OUT_WIDTH);
   localparam int unsigned       PTR_W      = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [PTR_W-1:0]  LAST_SLICE = PTR_W'(SLICES - 1);
   localparam logic [31:0]       RESEED_LIM = 32'(RESEED_WORDS);

   ks_state_t              state;
   logic                   op_first;
   logic [31:0]            reseed_cnt;
   logic                   ever_captured;
   logic [PTR_W-1:0]       slice_ptr;
   logic [PTR_W-1:0]       slice_ptr_nxt;
   logic [PTR_W-1:0]       slice_rev;
   logic [7:0]             slice_base;
   logic                   xfer;
   logic                   push;
   logic                   pop;
   logic                   starved;
   logic [1:0]             count;
   logic [DRBG_WORD_W-1:0] head;
   logic [DRBG_WORD_W-1:0] next_word;
   logic [DRBG_WORD_W-1:0] head_nxt;

   keystream_word_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .wr_data   (drbg_random_bits),
      .head      (head),
      .next_word (next_word),
      .count     (count)
   );

   assign ks_valid = (count != 2'd0);
   assign xfer     = ks_valid && ks_ready;
   assign pop      = xfer && (slice_ptr == LAST_SLICE);
   assign push     = (state == WAIT) && !op_first && drbg_next_ready && !drbg_busy;
   assign starved  = ks_ready && !ks_valid && enable && ever_captured;

   // ks_data is registered, so it is loaded from the word that will be at the head after this edge.
   always_comb begin
      head_nxt = head;
      if (pop) begin
         head_nxt = (count == 2'd2) ? next_word : drbg_random_bits;
      end else if (count == 2'd0) begin
         head_nxt = drbg_random_bits;
      end
   end

   assign slice_ptr_nxt = xfer ? (pop ? '0 : slice_ptr + 1'b1) : slice_ptr;
   assign slice_rev     = LAST_SLICE - slice_ptr_nxt;
   assign slice_base    = 8'(OUT_WIDTH * 32'(slice_rev));

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         op_first        <= 1'b0;
         drbg_next       <= 1'b0;
         drbg_reseed     <= 1'b0;
         reseed_cnt      <= '0;
         words_generated <= '0;
      end else begin
         drbg_next   <= 1'b0;
         drbg_reseed <= 1'b0;
         op_first    <= 1'b0;
         case (state)
            IDLE: begin
               if ((RESEED_WORDS != 0) && (reseed_cnt == RESEED_LIM)) begin
                  state <= RSD_REQ;
               end else if (enable && (count != 2'd2)) begin
                  state <= REQ;
               end
            end
            REQ: begin
               if (!drbg_busy) begin
                  drbg_next <= 1'b1;
                  op_first  <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (push) begin
                  words_generated <= words_generated + 32'd1;
                  reseed_cnt      <= reseed_cnt + 32'd1;
                  state           <= IDLE;
               end
            end
            RSD_REQ: begin
               if (!drbg_busy) begin
                  drbg_reseed <= 1'b1;
                  op_first    <= 1'b1;
                  state       <= RSD_WAIT;
               end
            end
            RSD_WAIT: begin
               if (!op_first && !drbg_busy) begin
                  reseed_cnt <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slice_ptr     <= '0;
         ks_data       <= '0;
         underrun      <= 1'b0;
         ever_captured <= 1'b0;
      end else begin
         slice_ptr <= slice_ptr_nxt;
         ks_data   <= head_nxt[slice_base +: OUT_WIDTH];
         underrun  <= starved;
         if (push) begin
            ever_captured <= 1'b1;
         end
      end
   end

`ifdef KEYSTREAM_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (starved && (underrun_count != 16'hFFFF)) begin
         underrun_count <= underrun_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// Self-checking bench for drbg_keystream_buffer with a behavioural Hash_DRBG model and slice scoreboard.
module tb_drbg_keystream_buffer;

   localparam int unsigned OW  = 32;
   localparam int unsigned NSL = 256 / OW;
   localparam logic [255:0] PATTERN = {2{128'h00112233445566778899AABBCCDDEEFF}};

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           enable = 1'b0;
   logic           ks_ready = 1'b0;
   logic           hold_busy = 1'b0;
   logic           drbg_next;
   logic           drbg_reseed;
   logic [255:0]   drbg_random_bits;
   logic           drbg_next_ready;
   logic           drbg_busy;
   logic [OW-1:0]  ks_data;
   logic           ks_valid;
   logic [31:0]    words_generated;
   logic           underrun;
`ifdef KEYSTREAM_UNDERRUN_CNT_EN
   logic [15:0]    underrun_count;
`endif

   int            n_pass = 0;
   int            n_total = 0;
   logic [OW-1:0] exp_q[$];

   // DRBG model state
   logic          m_busy = 1'b0;
   logic          m_ready = 1'b0;
   logic [255:0]  m_bits = '0;
   int            m_cd = 0;
   bit            m_rsd = 1'b0;
   int            m_k = 0;
   int            lat = 2;
   int            rsd_lat = 4;
   int            n_next = 0;
   int            n_rsd = 0;
   int            since_rsd = 0;

   // monitor state
   bit            seen_next = 1'b0;
   bit            seen_rsd = 1'b0;
   bit            ever = 1'b0;
   logic          exp_ur = 1'b0;
   int            ur_pulses = 0;

   always #5 clk = ~clk;

   assign drbg_busy        = m_busy | hold_busy;
   assign drbg_next_ready  = m_ready;
   assign drbg_random_bits = m_bits;

   drbg_keystream_buffer #(
      .OUT_WIDTH    (OW),
      .RESEED_WORDS (3)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .drbg_next        (drbg_next),
      .drbg_reseed      (drbg_reseed),
      .drbg_random_bits (drbg_random_bits),
      .drbg_next_ready  (drbg_next_ready),
      .drbg_busy        (drbg_busy),
      .ks_data          (ks_data),
      .ks_valid         (ks_valid),
      .ks_ready         (ks_ready),
      .words_generated  (words_generated),
      .underrun         (underrun)
`ifdef KEYSTREAM_UNDERRUN_CNT_EN
     ,.underrun_count   (underrun_count)
`endif
   );

   function automatic void check(string tag, logic [255:0] obs, logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endfunction

   function automatic logic [255:0] word_of(int k);
      return PATTERN ^ {8{32'(k)}};
   endfunction

   function automatic logic [OW-1:0] slice_of(logic [255:0] w, int i);
      logic [255:0] t;
      t = w >> (OW * (NSL - 1 - i));
      return t[OW-1:0];
   endfunction

   // Hash_DRBG model: reacts to requests latched on the previous falling edge.
   always @(posedge clk) begin
      if (reset) begin
         m_busy    <= 1'b0;
         m_ready   <= 1'b0;
         m_cd      <= 0;
         m_rsd     <= 1'b0;
         m_k       <= 0;
         n_next    <= 0;
         n_rsd     <= 0;
         since_rsd <= 0;
      end else if (m_cd != 0) begin
         if (m_cd == 1) begin
            m_busy <= 1'b0;
            if (!m_rsd) begin
               m_bits  <= word_of(m_k);
               m_ready <= 1'b1;
               for (int i = 0; i < NSL; i++) exp_q.push_back(slice_of(word_of(m_k), i));
               m_k       <= m_k + 1;
               since_rsd <= since_rsd + 1;
            end
         end
         m_cd <= m_cd - 1;
      end else if (seen_next) begin
         m_busy  <= 1'b1;
         m_ready <= 1'b0;
         m_cd    <= lat;
         m_rsd   <= 1'b0;
         n_next  <= n_next + 1;
      end else if (seen_rsd) begin
         m_busy    <= 1'b1;
         m_cd      <= rsd_lat;
         m_rsd     <= 1'b1;
         n_rsd     <= n_rsd + 1;
         since_rsd <= 0;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         seen_next = 1'b0;
         seen_rsd  = 1'b0;
         ever      = 1'b0;
         exp_ur    = 1'b0;
         ur_pulses = 0;
      end else begin
         check("underrun", underrun, exp_ur);
         if (underrun) ur_pulses++;
         ever   = ever | ks_valid;
         exp_ur = ks_ready && !ks_valid && enable && ever;
         seen_next = drbg_next;
         seen_rsd  = drbg_reseed;
         if (drbg_next || drbg_reseed) begin
            check("req_while_busy", drbg_busy, 1'b0);
            check("next_and_reseed", drbg_next && drbg_reseed, 1'b0);
         end
         if (drbg_next) check("next_before_reseed", since_rsd < 3, 1'b1);
         if (drbg_reseed) check("reseed_word_count", since_rsd, 3);
         if (ks_valid) begin
            if (exp_q.size() == 0) begin
               check("ks_valid_without_word", ks_valid, 1'b0);
            end else begin
               check("ks_data", ks_data, exp_q[0]);
               if (ks_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("rst_drbg_next", drbg_next, 1'b0);
      check("rst_drbg_reseed", drbg_reseed, 1'b0);
      check("rst_ks_valid", ks_valid, 1'b0);
      check("rst_ks_data", ks_data, '0);
      check("rst_words_generated", words_generated, '0);
      check("rst_underrun", underrun, 1'b0);
`ifdef KEYSTREAM_UNDERRUN_CNT_EN
      check("rst_underrun_count", underrun_count, '0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_valid(int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (ks_valid) break;
      end
   endtask

   task automatic wait_new_next(int limit);
      int n0;
      n0 = n_next;
      for (int i = 0; i < limit && n_next == n0; i++) @(posedge clk);
      #1;
      check("next_issued", n_next != n0, 1'b1);
   endtask

   initial begin
      int w0;
      int n0;

      // Reset state and basic streaming
      do_reset();
      lat = 2;
      enable = 1'b1;
      ks_ready = 1'b1;
      wait_valid(100);
      check("first_valid", ks_valid, 1'b1);
      check("first_slice", ks_data, 32'h00112233);
      check("words_after_first", words_generated, 1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("no_gap", ks_valid, 1'b1);
      end
      cyc(120);
      @(negedge clk);
      check("reseed_seen", n_rsd != 0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         ks_ready = 1'($urandom_range(0, 1));
      end
      ks_ready = 1'b1;
      cyc(20);

      // DRBG initialisation: busy held for 50 cycles
      hold_busy = 1'b1;
      do_reset();
      enable = 1'b1;
      cyc(50);
      @(negedge clk);
      check("init_no_next", n_next, 0);
      @(posedge clk);
      #1;
      hold_busy = 1'b0;
      wait_new_next(20);
      cyc(3);
      check("init_single_next", n_next, 1);
      cyc(30);

      // Consumer stalled: two words fill the buffer, no further requests
      do_reset();
      lat = 2;
      enable = 1'b1;
      ks_ready = 1'b0;
      cyc(100);
      @(negedge clk);
      check("stall_words", words_generated, 2);
      check("stall_next_count", n_next, 2);
      check("stall_valid", ks_valid, 1'b1);
      check("stall_data", ks_data, 32'h00112233);
      @(posedge clk);
      #1;
      ks_ready = 1'b1;
      cyc(20);

      // enable dropped while a word is in flight
      lat = 20;
      wait_new_next(100);
      n0 = n_next;
      @(negedge clk);
      w0 = words_generated;
      @(posedge clk);
      #1;
      enable = 1'b0;
      cyc(60);
      @(negedge clk);
      check("inflight_captured", words_generated, w0 + 1);
      check("no_next_after_disable", n_next, n0);
      check("drained", ks_valid, 1'b0);

      // Slow DRBG: consumer starves
      do_reset();
      lat = 80;
      enable = 1'b1;
      ks_ready = 1'b1;
      cyc(400);
      @(negedge clk);
      check("underrun_seen", ur_pulses != 0, 1'b1);
`ifdef KEYSTREAM_UNDERRUN_CNT_EN
      check("underrun_count", underrun_count, ur_pulses);
`endif

      // Reset while waiting on the DRBG
      lat = 30;
      wait_new_next(200);
      cyc(5);
      do_reset();
      lat = 2;
      wait_valid(100);
      check("restart_wait_slice", ks_data, 32'h00112233);
      check("restart_wait_words", words_generated, 1);

      // Reset with the head word half consumed
      for (int i = 0; i < 3; i++) @(negedge clk);
      do_reset();
      wait_valid(100);
      check("restart_half_slice", ks_data, 32'h00112233);
      check("restart_half_words", words_generated, 1);
      cyc(40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
